// File: rtl/spi_bus_monitor.sv
// Passive SPI bus monitor: rebuilds frames from SS_n/MOSI and flags short, long,
// multi-select and MISO-idle errors through registered pulses and saturating counters.
module spi_bus_monitor #(
  parameter int FRAME_BITS = 11,
  parameter int NUM_CH     = 1,
  parameter int CNT_W      = 16,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_CH-1:0]     SS_n,
  input  logic                  MOSI,
  input  logic                  MISO,
  input  logic                  clear,
  output logic                  frame_done,
  output logic [CH_W-1:0]       frame_ch,
  output logic [FRAME_BITS-1:0] frame_data,
  output logic                  err_short,
  output logic                  err_long,
  output logic                  err_multi_ss,
  output logic                  err_miso,
  output logic [3:0]            err_sticky,
  output logic [CNT_W-1:0]      frame_cnt,
  output logic [CNT_W-1:0]      err_cnt
);

  localparam int BC_W = $clog2(FRAME_BITS + 1);
  localparam logic [BC_W-1:0]  FULL    = BC_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, ACTIVE, OVERRUN, ABORT} state_t;

  state_t                state, state_nxt;
  logic [FRAME_BITS-1:0] shreg, shreg_nxt;
  logic [BC_W-1:0]       bit_cnt, bit_cnt_nxt;
  logic [CH_W-1:0]       ch, ch_nxt, first_ch;
  logic [4:0]            low_cnt;
  logic                  all_high, multi, sel_high, post_rst;
  logic                  done_nxt, short_nxt, long_nxt, multi_nxt, miso_nxt;
  logic [2:0]            err_inc;
  logic [CNT_W+2:0]      err_sum;
  logic [CNT_W-1:0]      err_cnt_nxt, frame_cnt_nxt;

  // Count selected lines, find the lowest selected channel and the latched line's level.
  always_comb begin
    low_cnt  = '0;
    first_ch = '0;
    sel_high = 1'b1;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (!SS_n[i]) begin
        low_cnt  = low_cnt + 5'd1;
        first_ch = CH_W'(i);
      end
      if (CH_W'(i) == ch) sel_high = SS_n[i];
    end
  end

  assign all_high = (low_cnt == 5'd0);
  assign multi    = (NUM_CH > 1) && (low_cnt > 5'd1);

  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    bit_cnt_nxt = bit_cnt;
    ch_nxt      = ch;
    done_nxt    = 1'b0;
    short_nxt   = 1'b0;
    long_nxt    = 1'b0;
    multi_nxt   = 1'b0;
    miso_nxt    = MISO && (post_rst || (state == IDLE && all_high));
    if (multi && state != ABORT) begin
      multi_nxt = 1'b1;
      state_nxt = ABORT;
    end else begin
      case (state)
        IDLE: if (!all_high) begin
          state_nxt   = ACTIVE;
          ch_nxt      = first_ch;
          shreg_nxt   = FRAME_BITS'(MOSI);
          bit_cnt_nxt = BC_W'(1);
        end
        ACTIVE: begin
          // A new select on another line in the closing cycle is ignored until its next low sample.
          if (sel_high) begin
            state_nxt = IDLE;
            done_nxt  = (bit_cnt == FULL);
            short_nxt = (bit_cnt != FULL);
          end else if (bit_cnt == FULL) begin
            state_nxt = OVERRUN;
          end else begin
            shreg_nxt   = {shreg[FRAME_BITS-2:0], MOSI};
            bit_cnt_nxt = bit_cnt + BC_W'(1);
          end
        end
        OVERRUN: if (sel_high) begin
          state_nxt = IDLE;
          long_nxt  = 1'b1;
        end
        ABORT: if (all_high) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign err_inc       = 3'(short_nxt) + 3'(long_nxt) + 3'(multi_nxt) + 3'(miso_nxt);
  assign err_sum       = {3'b000, err_cnt} + {{CNT_W{1'b0}}, err_inc};
  assign err_cnt_nxt   = (err_sum > {3'b000, CNT_MAX}) ? CNT_MAX : err_sum[CNT_W-1:0];
  assign frame_cnt_nxt = (done_nxt && frame_cnt != CNT_MAX) ? frame_cnt + CNT_W'(1) : frame_cnt;

  // NOTE: all state here is updated with non-blocking assignments so every register
  // samples the pre-edge values computed above, regardless of statement order.
  always_ff @(posedge clk) begin
    post_rst <= rst;
    if (rst) begin
      state        <= IDLE;
      shreg        <= '0;
      bit_cnt      <= '0;
      ch           <= '0;
      frame_done   <= 1'b0;
      frame_ch     <= '0;
      frame_data   <= '0;
      err_short    <= 1'b0;
      err_long     <= 1'b0;
      err_multi_ss <= 1'b0;
      err_miso     <= 1'b0;
      err_sticky   <= '0;
      frame_cnt    <= '0;
      err_cnt      <= '0;
    end else begin
      state        <= state_nxt;
      shreg        <= shreg_nxt;
      bit_cnt      <= bit_cnt_nxt;
      ch           <= ch_nxt;
      frame_done   <= done_nxt;
      err_short    <= short_nxt;
      err_long     <= long_nxt;
      err_multi_ss <= multi_nxt;
      err_miso     <= miso_nxt;
      if (done_nxt) begin
        frame_data <= shreg;
        frame_ch   <= ch;
      end
      // Clear takes priority over any increment landing in the same cycle.
      if (clear) begin
        err_sticky <= '0;
        frame_cnt  <= '0;
        err_cnt    <= '0;
      end else begin
        err_sticky <= err_sticky | {miso_nxt, multi_nxt, long_nxt, short_nxt};
        frame_cnt  <= frame_cnt_nxt;
        err_cnt    <= err_cnt_nxt;
      end
    end
  end

endmodule
